// File: rtl/vga_timing_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_timing_generator                                       |
// | Description : VGA raster timing (sync, coordinates, strobes) in the      |
// |               vga_clock domain. Define VGA_TIMING_PREFETCH_EN to enable   |
// |               the next-line prefetch request outputs.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_timing_generator #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int COORD_BITS      = 10
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  output logic                  hsync,
  output logic                  vsync,
  output logic [COORD_BITS-1:0] pixel_x,
  output logic [COORD_BITS-1:0] pixel_y,
  output logic                  visible,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  line_request,
  output logic [COORD_BITS-1:0] request_line
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_BITS-1:0] c_ONE      = COORD_BITS'(1);
  localparam logic [COORD_BITS-1:0] c_H_MAX    = COORD_BITS'(H_TOTAL - 1);
  localparam logic [COORD_BITS-1:0] c_V_MAX    = COORD_BITS'(V_TOTAL - 1);
  localparam logic [COORD_BITS-1:0] c_H_VIS    = COORD_BITS'(H_VISIBLE);
  localparam logic [COORD_BITS-1:0] c_V_VIS    = COORD_BITS'(V_VISIBLE);
  localparam logic [COORD_BITS-1:0] c_HS_START = COORD_BITS'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_BITS-1:0] c_HS_END   = COORD_BITS'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_BITS-1:0] c_VS_START = COORD_BITS'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_BITS-1:0] c_VS_END   = COORD_BITS'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic                  c_SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic [COORD_BITS-1:0] r_h;
  logic [COORD_BITS-1:0] r_v;
  logic [COORD_BITS-1:0] w_h_next;
  logic [COORD_BITS-1:0] w_v_next;
  logic                  w_hs_act;
  logic                  w_vs_act;

  // Outputs are decoded from the next counter values so every flop describes
  // the same (h, v) the counters hold after the edge.
  always_comb begin
    w_h_next = r_h + c_ONE;
    w_v_next = r_v;
    if (r_h == c_H_MAX) begin
      w_h_next = '0;
      w_v_next = (r_v == c_V_MAX) ? '0 : r_v + c_ONE;
    end
    w_hs_act = (w_h_next >= c_HS_START) && (w_h_next <= c_HS_END);
    w_vs_act = (w_v_next >= c_VS_START) && (w_v_next <= c_VS_END);
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_h         <= c_H_MAX;
      r_v         <= c_V_MAX;
      hsync       <= c_SYNC_IDLE;
      vsync       <= c_SYNC_IDLE;
      pixel_x     <= '0;
      pixel_y     <= '0;
      visible     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_h         <= w_h_next;
      r_v         <= w_v_next;
      hsync       <= w_hs_act ^ c_SYNC_IDLE;
      vsync       <= w_vs_act ^ c_SYNC_IDLE;
      pixel_x     <= w_h_next;
      pixel_y     <= w_v_next;
      visible     <= (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
      line_start  <= (w_h_next == '0);
      frame_start <= (w_h_next == '0) && (w_v_next == '0);
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  logic [COORD_BITS-1:0] w_req_line;
  logic                  w_req_fire;

  // At the end of the visible part of a line, ask for the following line.
  always_comb begin
    w_req_line = (w_v_next == c_V_MAX) ? '0 : w_v_next + c_ONE;
    w_req_fire = (w_h_next == c_H_VIS) && (w_req_line < c_V_VIS);
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      line_request <= 1'b0;
      request_line <= '0;
    end else begin
      line_request <= w_req_fire;
      request_line <= w_req_fire ? w_req_line : '0;
    end
  end
`else
  assign line_request = 1'b0;
  assign request_line = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_timing_generator                                    |
// | Description : Self-checking bench: default-timing instance checked by a  |
// |               vector table, small-timing instance checked every cycle.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vga_timing_generator;

`ifdef VGA_TIMING_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  // Reduced timing so whole frames fit in a short run: 15 x 10 = 150 cycles.
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync, vsync, vis, ls, fs, lr;
  logic [9:0] px, py, rl;
  logic       s_hsync, s_vsync, s_vis, s_ls, s_fs, s_lr;
  logic [9:0] s_px, s_py, s_rl;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  vga_timing_generator dut (
    .vga_clock(clk), .reset(rst), .hsync(hsync), .vsync(vsync),
    .pixel_x(px), .pixel_y(py), .visible(vis), .line_start(ls),
    .frame_start(fs), .line_request(lr), .request_line(rl)
  );

  vga_timing_generator #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_ACTIVE_LOW(1'b0), .COORD_BITS(10)
  ) dut_s (
    .vga_clock(clk), .reset(rst), .hsync(s_hsync), .vsync(s_vsync),
    .pixel_x(s_px), .pixel_y(s_py), .visible(s_vis), .line_start(s_ls),
    .frame_start(s_fs), .line_request(s_lr), .request_line(s_rl)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_default(input string tag);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_visible"}, int'(vis), 0);
    chk({tag, "_line_start"}, int'(ls), 0);
    chk({tag, "_frame_start"}, int'(fs), 0);
    chk({tag, "_line_request"}, int'(lr), 0);
    chk({tag, "_pixel_x"}, int'(px), 0);
    chk({tag, "_pixel_y"}, int'(py), 0);
    chk({tag, "_request_line"}, int'(rl), 0);
  endtask

  // Independent raster model for the small instance, advanced once per cycle.
  int  mh, mv, mn;
  bit  e_lr;
  always @(negedge clk) begin
    if (rst) begin
      mh = S_HT - 1;
      mv = S_VT - 1;
      chk("s_rst_hsync", int'(s_hsync), 0);
      chk("s_rst_vsync", int'(s_vsync), 0);
      chk("s_rst_frame_start", int'(s_fs), 0);
      chk("s_rst_pixel_x", int'(s_px), 0);
    end else begin
      if (mh == S_HT - 1) begin
        mh = 0;
        mv = (mv == S_VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      mn   = (mv + 1) % S_VT;
      e_lr = PF && (mh == S_HV) && (mn < S_VV);
      chk("s_pixel_x", int'(s_px), mh);
      chk("s_pixel_y", int'(s_py), mv);
      chk("s_hsync", int'(s_hsync), int'(mh >= S_HV + S_HF && mh <= S_HV + S_HF + S_HS - 1));
      chk("s_vsync", int'(s_vsync), int'(mv >= S_VV + S_VF && mv <= S_VV + S_VF + S_VS - 1));
      chk("s_visible", int'(s_vis), int'(mh < S_HV && mv < S_VV));
      chk("s_line_start", int'(s_ls), int'(mh == 0));
      chk("s_frame_start", int'(s_fs), int'(mh == 0 && mv == 0));
      chk("s_line_request", int'(s_lr), int'(e_lr));
      if (e_lr || !PF) chk("s_request_line", int'(s_rl), e_lr ? mn : 0);
    end
  end

  typedef struct {
    int cyc; int x; int y;
    bit hs; bit vs; bit vis; bit ls; bit fs; bit lr; int rl;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // cycle index counts edges after reset release; cycle 0 is (0,0)
    vecs[0]  = '{0,    0,   0, 1, 1, 1, 1, 1, 1'b0, 0};
    vecs[1]  = '{1,    1,   0, 1, 1, 1, 0, 0, 1'b0, 0};
    vecs[2]  = '{639,  639, 0, 1, 1, 1, 0, 0, 1'b0, 0};
    vecs[3]  = '{640,  640, 0, 1, 1, 0, 0, 0, PF,   PF ? 1 : 0};
    vecs[4]  = '{641,  641, 0, 1, 1, 0, 0, 0, 1'b0, 0};
    vecs[5]  = '{655,  655, 0, 1, 1, 0, 0, 0, 1'b0, 0};
    vecs[6]  = '{656,  656, 0, 0, 1, 0, 0, 0, 1'b0, 0};
    vecs[7]  = '{751,  751, 0, 0, 1, 0, 0, 0, 1'b0, 0};
    vecs[8]  = '{752,  752, 0, 1, 1, 0, 0, 0, 1'b0, 0};
    vecs[9]  = '{799,  799, 0, 1, 1, 0, 0, 0, 1'b0, 0};
    vecs[10] = '{800,  0,   1, 1, 1, 1, 1, 0, 1'b0, 0};
    vecs[11] = '{1440, 640, 1, 1, 1, 0, 0, 0, PF,   PF ? 2 : 0};
    vecs[12] = '{1441, 641, 1, 1, 1, 0, 0, 0, 1'b0, 0};
    vecs[13] = '{1600, 0,   2, 1, 1, 1, 1, 0, 1'b0, 0};
    vecs[14] = '{1650, 50,  2, 1, 1, 1, 0, 0, 1'b0, 0};

    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_default("rst");
    #1 rst = 1'b0;
    cyc = -1;

    for (int i = 0; i < 15; i++) begin
      while (cyc < vecs[i].cyc) step();
      chk($sformatf("v%0d_pixel_x", i), int'(px), vecs[i].x);
      chk($sformatf("v%0d_pixel_y", i), int'(py), vecs[i].y);
      chk($sformatf("v%0d_hsync", i), int'(hsync), int'(vecs[i].hs));
      chk($sformatf("v%0d_vsync", i), int'(vsync), int'(vecs[i].vs));
      chk($sformatf("v%0d_visible", i), int'(vis), int'(vecs[i].vis));
      chk($sformatf("v%0d_line_start", i), int'(ls), int'(vecs[i].ls));
      chk($sformatf("v%0d_frame_start", i), int'(fs), int'(vecs[i].fs));
      chk($sformatf("v%0d_line_request", i), int'(lr), int'(vecs[i].lr));
      if (vecs[i].lr || !PF) chk($sformatf("v%0d_request_line", i), int'(rl), vecs[i].rl);
    end

    // Mid-frame asynchronous reset at (300, 2), asserted between edges.
    while (cyc < 1900) step();
    chk("pre_async_pixel_x", int'(px), 300);
    chk("pre_async_pixel_y", int'(py), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_default("async");
    chk("async_s_hsync", int'(s_hsync), 0);
    chk("async_s_visible", int'(s_vis), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    cyc = -1;
    step();
    chk("restart_frame_start", int'(fs), 1);
    chk("restart_line_start", int'(ls), 1);
    chk("restart_visible", int'(vis), 1);
    chk("restart_pixel_x", int'(px), 0);
    chk("restart_pixel_y", int'(py), 0);
    chk("restart_hsync", int'(hsync), 1);
    while (cyc < 800) step();
    chk("restart_l1_line_start", int'(ls), 1);
    chk("restart_l1_frame_start", int'(fs), 0);
    chk("restart_l1_pixel_y", int'(py), 1);
    repeat (400) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
